// File: rtl/instr_issue_scheduler_pkg.sv
// Shared types for the instruction issue path: instruction format, control
// opcodes and the opcode classifier used by the scheduler.
package instr_issue_scheduler_pkg;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [31:0] length;
    logic [15:0] acc_addr;
  } instr_type;

  localparam instr_type INIT_INSTR = '0;

  localparam logic [7:0] OPCODE_NOP  = 8'h00;
  localparam logic [7:0] OPCODE_HALT = 8'h01;
  localparam logic [7:0] OPCODE_SYNC = 8'hFF;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_HALT,
    CLS_SYNC,
    CLS_WEIGHT,
    CLS_MATRIX,
    CLS_ACTIVATION,
    CLS_ILLEGAL
  } instr_class_type;

  // Exact control opcodes are tested first so 8'hFF never lands in ACTIVATION.
  function automatic instr_class_type classify_opcode(input logic [7:0] op);
    if (op == OPCODE_NOP)            return CLS_NOP;
    else if (op == OPCODE_HALT)      return CLS_HALT;
    else if (op == OPCODE_SYNC)      return CLS_SYNC;
    else if (op[7:3] == 5'b00001)    return CLS_WEIGHT;
    else if (op[7:5] == 3'b001)      return CLS_MATRIX;
    else if (op[7])                  return CLS_ACTIVATION;
    else                             return CLS_ILLEGAL;
  endfunction

endpackage

// File: rtl/instr_issue_scheduler_if.sv
// Host-side and coordinator-side signals of the issue scheduler; the slave
// modport is the scheduler's view, master is the surrounding logic's view.
interface instr_issue_scheduler_if;
  import instr_issue_scheduler_pkg::*;

  logic        enable;
  instr_type   in_instr;
  logic        in_valid;
  logic        in_ready;
  logic        resume;
  logic        coord_busy;
  logic        weight_busy;
  logic        matrix_busy;
  logic        activation_busy;
  instr_type   instr;
  logic        instr_enable;
  logic        synchronize;
  logic        halted;
  logic        illegal_opcode;
  logic [31:0] issue_count;

  modport slave (
    input  enable, in_instr, in_valid, resume,
    input  coord_busy, weight_busy, matrix_busy, activation_busy,
    output in_ready, instr, instr_enable, synchronize, halted,
    output illegal_opcode, issue_count
  );

  modport master (
    output enable, in_instr, in_valid, resume,
    output coord_busy, weight_busy, matrix_busy, activation_busy,
    input  in_ready, instr, instr_enable, synchronize, halted,
    input  illegal_opcode, issue_count
  );

endinterface

// File: rtl/instr_issue_scheduler_fifo.sv
// Synchronous instruction FIFO; head is the registered oldest entry, so there
// is no fall-through from push to head within a cycle.
module instr_fifo
  import instr_issue_scheduler_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push_i,
  input  instr_type data_i,
  input  logic      pop_i,
  output instr_type head_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  instr_type       mem_q [DEPTH];
  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;
  logic            push_ok, pop_ok;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/instr_issue_scheduler.sv
// Issues buffered host instructions to the control coordinator one at a time
// and executes SYNC (drain then pulse) and HALT (park until resume) locally.
module instr_issue_scheduler
  import instr_issue_scheduler_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned SYNC_GUARD = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  instr_issue_scheduler_if.slave   bus
);

  localparam int unsigned GW = (SYNC_GUARD > 1) ? $clog2(SYNC_GUARD + 1) : 1;

  localparam logic [1:0] ST_ISSUE     = 2'd0;
  localparam logic [1:0] ST_WAIT_SYNC = 2'd1;
  localparam logic [1:0] ST_HALTED    = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [GW-1:0]   guard_q, guard_d;
  instr_type       instr_q, instr_d;
  logic            instr_en_q, instr_en_d;
  logic            sync_q, sync_d;
  logic            illegal_q, illegal_d;
  logic [31:0]     count_q, count_d;

  instr_type       head;
  logic            full, empty, push, pop;
  instr_class_type head_cls;
  logic            units_idle;

  assign bus.in_ready = !full && (state_q != ST_HALTED);
  assign push         = bus.in_valid && bus.in_ready;
  assign head_cls     = classify_opcode(head.opcode);
  assign units_idle   = !(bus.coord_busy || bus.weight_busy ||
                          bus.matrix_busy || bus.activation_busy);

  instr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (bus.in_instr),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    state_d    = state_q;
    guard_d    = guard_q;
    instr_d    = instr_q;
    instr_en_d = 1'b0;
    sync_d     = 1'b0;
    illegal_d  = illegal_q;
    count_d    = count_q;
    pop        = 1'b0;
    case (state_q)
      ST_ISSUE: begin
        if (bus.enable && !empty) begin
          case (head_cls)
            // Waiting on our own strobe limits issues to one every two cycles.
            CLS_WEIGHT, CLS_MATRIX, CLS_ACTIVATION: begin
              if (!bus.coord_busy && !instr_en_q) begin
                pop        = 1'b1;
                instr_d    = head;
                instr_en_d = 1'b1;
                count_d    = count_q + 32'd1;
              end
            end
            CLS_NOP: pop = 1'b1;
            CLS_ILLEGAL: begin
              pop       = 1'b1;
              illegal_d = 1'b1;
            end
            CLS_SYNC: begin
              pop     = 1'b1;
              state_d = ST_WAIT_SYNC;
              guard_d = GW'(SYNC_GUARD);
            end
            CLS_HALT: begin
              pop     = 1'b1;
              state_d = ST_HALTED;
            end
            default: ;
          endcase
        end
      end
      ST_WAIT_SYNC: begin
        if (guard_q != '0) begin
          guard_d = guard_q - GW'(1);
        end else if (units_idle) begin
          sync_d  = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_HALTED: begin
        if (bus.resume) state_d = ST_ISSUE;
      end
      default: state_d = ST_ISSUE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_ISSUE;
      guard_q    <= '0;
      instr_q    <= INIT_INSTR;
      instr_en_q <= 1'b0;
      sync_q     <= 1'b0;
      illegal_q  <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      guard_q    <= guard_d;
      instr_q    <= instr_d;
      instr_en_q <= instr_en_d;
      sync_q     <= sync_d;
      illegal_q  <= illegal_d;
      count_q    <= count_d;
    end
  end

  assign bus.instr          = instr_q;
  assign bus.instr_enable   = instr_en_q;
  assign bus.synchronize    = sync_q;
  assign bus.halted         = (state_q == ST_HALTED);
  assign bus.illegal_opcode = illegal_q;
  assign bus.issue_count    = count_q;

endmodule

// File: tb/tb_instr_issue_scheduler.sv
// Directed bench for instr_issue_scheduler: expected issues are queued at push
// time and checked by a separate monitor that watches instr_enable.
module tb_instr_issue_scheduler;
  import instr_issue_scheduler_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  instr_issue_scheduler_if bus();

  instr_issue_scheduler #(.FIFO_DEPTH(8), .SYNC_GUARD(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          total = 0;
  int          bad   = 0;
  int unsigned cyc   = 0;
  int unsigned n_issued = 0;
  instr_type   exp_q[$];
  int unsigned issue_cyc[$];
  int unsigned sync_cyc[$];
  instr_type   mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every issue strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.instr_enable) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_issue: got instr %0h expected no issue", bus.instr);
        end else begin
          mon_e = exp_q.pop_front();
          chk("issue_instr", bus.instr, mon_e);
          chk("issue_count_at_issue", bus.issue_count, n_issued + 1);
          n_issued++;
          issue_cyc.push_back(cyc);
        end
      end
      if (bus.synchronize) sync_cyc.push_back(cyc);
    end
  end

  function automatic instr_type mk(input logic [7:0] op, input logic [31:0] len,
                                   input logic [15:0] addr);
    instr_type t;
    t.opcode   = op;
    t.length   = len;
    t.acc_addr = addr;
    return t;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    chk("leftover_expect", exp_q.size(), 0);
    exp_q.delete();
    issue_cyc.delete();
    sync_cyc.delete();
    n_issued = 0;
    bus.in_valid        = 1'b0;
    bus.resume          = 1'b0;
    bus.enable          = 1'b1;
    bus.coord_busy      = 1'b0;
    bus.weight_busy     = 1'b0;
    bus.matrix_busy     = 1'b0;
    bus.activation_busy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Caller is just after a posedge; returns just after the accepting edge.
  task automatic push(input instr_type x, input bit expect_issue, output int unsigned acc);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_instr = x;
    if (expect_issue) exp_q.push_back(x);
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    acc = cyc;
    bus.in_valid = 1'b0;
    if (!ok) chk("push_timeout", 0, 1);
  endtask

  task automatic wait_issues(input int unsigned n, input int unsigned budget, input string name);
    for (int unsigned i = 0; i < budget && n_issued < n; i++) @(posedge clk);
    if (n_issued < n) chk(name, n_issued, n);
  endtask

  int unsigned a0, a1, clr, r;

  initial begin
    bus.enable          = 1'b1;
    bus.in_instr        = INIT_INSTR;
    bus.in_valid        = 1'b0;
    bus.resume          = 1'b0;
    bus.coord_busy      = 1'b0;
    bus.weight_busy     = 1'b0;
    bus.matrix_busy     = 1'b0;
    bus.activation_busy = 1'b0;

    // Reset state
    #12;
    chk("rst_instr", bus.instr, INIT_INSTR);
    chk("rst_instr_enable", bus.instr_enable, 0);
    chk("rst_synchronize", bus.synchronize, 0);
    chk("rst_halted", bus.halted, 0);
    chk("rst_illegal", bus.illegal_opcode, 0);
    chk("rst_issue_count", bus.issue_count, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    do_reset();

    // Single weight instruction and issue latency
    push(mk(8'h08, 32'h500, 16'h0A30), 1'b1, a0);
    wait_issues(1, 20, "single_issue_timeout");
    if (issue_cyc.size() > 0) chk("single_latency", issue_cyc[0] - a0, 1);
    @(negedge clk);
    chk("single_strobe_one_cycle", bus.instr_enable, 0);
    chk("single_issue_count", bus.issue_count, 1);
    chk("single_instr_held", bus.instr, mk(8'h08, 32'h500, 16'h0A30));

    // Back-pressure: fill while coordinator busy, then drain
    do_reset();
    bus.coord_busy = 1'b1;
    for (int i = 0; i < 8; i++) push(mk(8'h21, 32'(i), 16'(i + 16'h100)), 1'b1, a0);
    @(negedge clk);
    chk("bp_full_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_instr = mk(8'h21, 32'd99, 16'd99);
    repeat (3) begin
      @(negedge clk);
      chk("bp_ninth_blocked", bus.in_ready, 0);
    end
    bus.in_valid   = 1'b0;
    bus.coord_busy = 1'b0;
    wait_issues(8, 60, "bp_drain_timeout");
    if (issue_cyc.size() == 8)
      for (int i = 1; i < 8; i++) chk("bp_spacing", issue_cyc[i] - issue_cyc[i-1], 2);
    @(negedge clk);
    chk("bp_issue_count", bus.issue_count, 8);

    // SYNC waits for weight_busy and the guard before pulsing
    do_reset();
    bus.weight_busy = 1'b1;
    push(mk(8'h08, 32'h10, 16'h0001), 1'b1, a0);
    push(mk(OPCODE_SYNC, 32'h0, 16'h0), 1'b0, a0);
    push(mk(8'h80, 32'h20, 16'h0002), 1'b1, a0);
    chk("sync_weight_issued", issue_cyc.size(), 1);
    if (issue_cyc.size() > 0)
      for (int i = 0; i < 20 && cyc < issue_cyc[0] + 5; i++) begin
        @(posedge clk);
        #1;
      end
    bus.weight_busy = 1'b0;
    clr = cyc;
    chk("sync_none_while_busy", sync_cyc.size(), 0);
    wait_issues(2, 30, "sync_act_timeout");
    @(negedge clk);
    chk("sync_pulse_count", sync_cyc.size(), 1);
    if (sync_cyc.size() == 1 && issue_cyc.size() == 2) begin
      chk("sync_pulse_time", sync_cyc[0], clr + 1);
      chk("sync_act_after_pulse", issue_cyc[1], sync_cyc[0] + 1);
    end

    // SYNC with idle units: only the guard delays the pulse
    do_reset();
    push(mk(OPCODE_SYNC, 32'h0, 16'h0), 1'b0, a0);
    repeat (10) @(negedge clk);
    chk("guard_pulse_count", sync_cyc.size(), 1);
    if (sync_cyc.size() == 1) chk("guard_pulse_time", sync_cyc[0], a0 + 4);

    // HALT / resume
    do_reset();
    push(mk(OPCODE_HALT, 32'h0, 16'h0), 1'b0, a0);
    push(mk(8'h20, 32'h33, 16'h0044), 1'b1, a1);
    repeat (20) begin
      @(negedge clk);
      chk("halt_halted", bus.halted, 1);
      chk("halt_in_ready", bus.in_ready, 0);
    end
    chk("halt_no_issue", n_issued, 0);
    @(posedge clk);
    #1 bus.resume = 1'b1;
    @(posedge clk);
    #1 bus.resume = 1'b0;
    r = cyc;
    @(negedge clk);
    chk("resume_halted_low", bus.halted, 0);
    wait_issues(1, 20, "resume_issue_timeout");
    if (issue_cyc.size() > 0) chk("resume_issue_time", issue_cyc[0], r + 1);

    // NOP / illegal / enable gating
    do_reset();
    bus.enable = 1'b0;
    push(mk(OPCODE_NOP, 32'h0, 16'h0), 1'b0, a0);
    push(mk(8'h42, 32'h0, 16'h0), 1'b0, a0);
    push(mk(8'h08, 32'h77, 16'h0888), 1'b1, a0);
    repeat (10) @(negedge clk);
    chk("en0_no_issue", n_issued, 0);
    chk("en0_no_illegal", bus.illegal_opcode, 0);
    bus.enable = 1'b1;
    wait_issues(1, 20, "en1_issue_timeout");
    repeat (10) @(negedge clk);
    chk("en1_illegal_sticky", bus.illegal_opcode, 1);
    chk("en1_issue_count", bus.issue_count, 1);
    chk("en1_issued", n_issued, 1);

    // Asynchronous reset while in WAIT_SYNC with a loaded FIFO
    do_reset();
    bus.weight_busy = 1'b1;
    push(mk(8'h08, 32'h5, 16'h0055), 1'b1, a0);
    push(mk(OPCODE_SYNC, 32'h0, 16'h0), 1'b0, a0);
    for (int i = 0; i < 4; i++) push(mk(8'h20, 32'(i), 16'h0), 1'b0, a0);
    repeat (5) @(negedge clk);
    chk("arst_pre_count", bus.issue_count, 1);
    chk("arst_pre_no_sync", sync_cyc.size(), 0);
    #2 rst = 1'b0;
    #1;
    chk("arst_issue_count", bus.issue_count, 0);
    chk("arst_instr", bus.instr, INIT_INSTR);
    chk("arst_instr_enable", bus.instr_enable, 0);
    chk("arst_in_ready", bus.in_ready, 1);
    chk("arst_leftover_expect", exp_q.size(), 0);
    exp_q.delete();
    issue_cyc.delete();
    sync_cyc.delete();
    n_issued = 0;
    bus.weight_busy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (15) @(negedge clk);
    chk("arst_post_no_issue", n_issued, 0);
    chk("arst_post_no_sync", sync_cyc.size(), 0);
    chk("arst_post_count", bus.issue_count, 0);
    chk("final_leftover_expect", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
